// File: rtl/regbank_ctrl_if.sv
// Purpose: bundles the command, response and register-bank signals of regbank_ctrl.
// Latency: none; this is wiring only.
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready are valid-ready pairs.
// Ports (slave = controller side):
//   cmd_*        command channel (op, dst, src1, src2, imm) into the controller
//   rsp_*        response channel (data, carry) out of the controller
//   rb_*         select/write lines to the 4-entry bank and its combinational read data
interface regbank_ctrl_if #(
  parameter int DATA_W = 32
);
  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [1:0]        cmd_dst;
  logic [1:0]        cmd_src1;
  logic [1:0]        cmd_src2;
  logic [DATA_W-1:0] cmd_imm;

  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;

  // register bank port
  logic [1:0]        rb_sr1;
  logic [1:0]        rb_sr2;
  logic [1:0]        rb_dr;
  logic              rb_write;
  logic [DATA_W-1:0] rb_wrData;
  logic [DATA_W-1:0] rb_rdData1;
  logic [DATA_W-1:0] rb_rdData2;

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_carry,
    input  rsp_ready,
    output rb_sr1, rb_sr2, rb_dr, rb_write, rb_wrData,
    input  rb_rdData1, rb_rdData2
  );

  // Command source / response sink / bank side.
  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_carry,
    output rsp_ready,
    input  rb_sr1, rb_sr2, rb_dr, rb_write, rb_wrData,
    output rb_rdData1, rb_rdData2
  );
endinterface

// File: rtl/regbank_ctrl.sv
// Purpose: sequences LOAD/MOVE/ADD/READ commands against an external 4-entry register bank.
// Latency: accept at edge T, bank write during cycle T+2, response valid from T+3 (4-cycle minimum spacing).
// Backpressure: cmd_ready only in IDLE; the response holds stable in RSP until rsp_ready.
// Ports:
//   clk  - single clock, all state changes on its rising edge
//   rst  - asynchronous active-high reset; aborts any command in flight
//   bus  - regbank_ctrl_if.slave: command channel, response channel, bank select/write lines
module regbank_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  regbank_ctrl_if.slave bus
);

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_MOVE = 2'd1;
  localparam logic [1:0] OP_ADD  = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Fields latched at acceptance; the cmd_* inputs are ignored afterwards.
  logic [1:0]        r_op;
  logic [1:0]        r_dst;
  logic [1:0]        r_src1;
  logic [1:0]        r_src2;
  logic [DATA_W-1:0] r_imm;

  // Operands captured from the bank at the end of RD.
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;

  logic              w_accept;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_result;
  logic              w_carry;

  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RD;
      S_RD:    w_next = S_WR;
      S_WR:    w_next = S_RSP;
      S_RSP:   if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Command latch and operand capture
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= OP_LOAD;
      r_dst  <= 2'd0;
      r_src1 <= 2'd0;
      r_src2 <= 2'd0;
      r_imm  <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= bus.cmd_op;
        r_dst  <= bus.cmd_dst;
        r_src1 <= bus.cmd_src1;
        r_src2 <= bus.cmd_src2;
        r_imm  <= bus.cmd_imm;
      end
      // The bank read ports are already pointed at src1/src2 during RD,
      // so operands reflect the bank before this command's own write.
      if (r_state == S_RD) begin
        r_a <= bus.rb_rdData1;
        r_b <= bus.rb_rdData2;
      end
    end
  end

  // ---------------------------------------------------------------
  // Result datapath
  // ---------------------------------------------------------------
  // Built only from latched registers, so rb_wrData/rsp_data change only
  // when a new command is accepted or operands are captured.
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    case (r_op)
      OP_LOAD: w_result = r_imm;
      OP_MOVE: w_result = r_a;
      OP_ADD: begin
        w_result = w_sum[DATA_W-1:0];
        w_carry  = w_sum[DATA_W];
      end
      OP_READ: w_result = r_a;
      default: w_result = '0;
    endcase
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign bus.cmd_ready = (r_state == S_IDLE);

  assign bus.rsp_valid = (r_state == S_RSP);
  assign bus.rsp_data  = w_result;
  assign bus.rsp_carry = w_carry;

  // Selects follow the latched fields and therefore hold between commands.
  assign bus.rb_sr1    = r_src1;
  assign bus.rb_sr2    = r_src2;
  assign bus.rb_dr     = r_dst;
  assign bus.rb_wrData = w_result;
  // Decoded from the state register, so an asynchronous reset removes the
  // write strobe immediately.
  assign bus.rb_write  = (r_state == S_WR) && (r_op != OP_READ);

endmodule

// File: tb/tb_regbank_ctrl.sv
module tb_regbank_ctrl;

  localparam int DATA_W = 32;

  logic clk;
  logic rst;

  regbank_ctrl_if #(.DATA_W(DATA_W)) bus ();

  regbank_ctrl #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural 4-entry register bank: combinational reads, write on posedge.
  logic [DATA_W-1:0] bank [4];

  always_ff @(posedge clk) begin
    if (bus.rb_write) bank[bus.rb_dr] <= bus.rb_wrData;
  end

  assign bus.rb_rdData1 = bank[bus.rb_sr1];
  assign bus.rb_rdData2 = bank[bus.rb_sr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]        op;
    logic [1:0]        dst;
    logic [1:0]        s1;
    logic [1:0]        s2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] exp_data;
    logic              exp_carry;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, check every phase, optionally stall the response.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] dst,
                         input logic [1:0] s1, input logic [1:0] s2,
                         input logic [DATA_W-1:0] imm,
                         input logic [DATA_W-1:0] exp_data, input logic exp_carry,
                         input int hold);
    int n;
    logic wr;
    n  = 0;
    wr = (op != 2'd3);
    while (!bus.cmd_ready && n < 20) begin
      step();
      n++;
    end
    chk("idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_op    = op;
    bus.cmd_dst   = dst;
    bus.cmd_src1  = s1;
    bus.cmd_src2  = s2;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = (hold == 0);
    step();  // accepted; now in RD
    // Scramble the fields so any late sampling shows up.
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = ~op;
    bus.cmd_dst   = ~dst;
    bus.cmd_src1  = ~s1;
    bus.cmd_src2  = ~s2;
    bus.cmd_imm   = ~imm;
    chk("rd_sr1", {30'd0, bus.rb_sr1}, {30'd0, s1});
    chk("rd_sr2", {30'd0, bus.rb_sr2}, {30'd0, s2});
    chk("rd_nowrite", {31'd0, bus.rb_write}, 32'd0);
    chk("rd_busy", {31'd0, bus.cmd_ready}, 32'd0);
    step();  // WR
    chk("wr_write", {31'd0, bus.rb_write}, {31'd0, wr});
    if (wr) begin
      chk("wr_dr", {30'd0, bus.rb_dr}, {30'd0, dst});
      chk("wr_data", bus.rb_wrData, exp_data);
    end
    step();  // RSP
    chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("rsp_carry", {31'd0, bus.rsp_carry}, {31'd0, exp_carry});
    chk("rsp_nowrite", {31'd0, bus.rb_write}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_data", bus.rsp_data, exp_data);
      chk("hold_busy", {31'd0, bus.cmd_ready}, 32'd0);
      chk("hold_nowrite", {31'd0, bus.rb_write}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    step();  // back to IDLE
    chk("done_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("done_ready", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [DATA_W-1:0] e;

    //           op    dst   s1    s2    imm            exp_data       carry
    vecs[0]  = '{2'd0, 2'd2, 2'd0, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{2'd0, 2'd0, 2'd1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{2'd0, 2'd1, 2'd3, 2'd0, 32'h00000001, 32'h00000001, 1'b0};
    vecs[3]  = '{2'd2, 2'd3, 2'd0, 2'd1, 32'h00000000, 32'h00000000, 1'b1};
    vecs[4]  = '{2'd3, 2'd0, 2'd3, 2'd0, 32'h0000FFFF, 32'h00000000, 1'b0};
    vecs[5]  = '{2'd0, 2'd1, 2'd0, 2'd0, 32'h00000005, 32'h00000005, 1'b0};
    vecs[6]  = '{2'd2, 2'd1, 2'd1, 2'd1, 32'h00000000, 32'h0000000A, 1'b0};
    vecs[7]  = '{2'd1, 2'd0, 2'd1, 2'd2, 32'h00000077, 32'h0000000A, 1'b0};
    vecs[8]  = '{2'd3, 2'd2, 2'd0, 2'd3, 32'h00000000, 32'h0000000A, 1'b0};
    vecs[9]  = '{2'd2, 2'd2, 2'd2, 2'd0, 32'h00000000, 32'hDEADBEF9, 1'b0};
    vecs[10] = '{2'd2, 2'd3, 2'd2, 2'd2, 32'h00000000, 32'hBD5B7DF2, 1'b1};
    vecs[11] = '{2'd3, 2'd1, 2'd3, 2'd1, 32'h00000000, 32'hBD5B7DF2, 1'b0};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_dst   = 2'd0;
    bus.cmd_src1  = 2'd0;
    bus.cmd_src2  = 2'd0;
    bus.cmd_imm   = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_carry", {31'd0, bus.rsp_carry}, 32'd0);
    chk("rst_rb_write", {31'd0, bus.rb_write}, 32'd0);
    chk("rst_rb_sr1", {30'd0, bus.rb_sr1}, 32'd0);
    chk("rst_rb_sr2", {30'd0, bus.rb_sr2}, 32'd0);
    chk("rst_rb_dr", {30'd0, bus.rb_dr}, 32'd0);
    chk("rst_rb_wrdata", bus.rb_wrData, 32'd0);
    rst = 1'b0;
    step();

    // Table-driven command stream
    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i].op, vecs[i].dst, vecs[i].s1, vecs[i].s2, vecs[i].imm,
              vecs[i].exp_data, vecs[i].exp_carry, 0);
    end

    // Response stalled for 6 cycles
    run_cmd(2'd0, 2'd0, 2'd0, 2'd0, 32'h000055AA, 32'h000055AA, 1'b0, 6);

    // Reset asserted during the WR cycle of LOAD R1=0x1234
    bus.cmd_op    = 2'd0;
    bus.cmd_dst   = 2'd1;
    bus.cmd_src1  = 2'd0;
    bus.cmd_src2  = 2'd0;
    bus.cmd_imm   = 32'h00001234;
    bus.cmd_valid = 1'b1;
    step();          // RD
    bus.cmd_valid = 1'b0;
    step();          // WR
    chk("abort_pre_write", {31'd0, bus.rb_write}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_write_drop", {31'd0, bus.rb_write}, 32'd0);
    chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    step();
    chk("abort_edge_write", {31'd0, bus.rb_write}, 32'd0);
    rst = 1'b0;
    step();
    chk("abort_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
    run_cmd(2'd3, 2'd0, 2'd1, 2'd0, 32'h0, 32'h0000000A, 1'b0, 0);

    // cmd_valid held high with fields changing every cycle
    acc           = 0;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.cmd_op   = 2'd0;
      bus.cmd_dst  = 2'((i / 4) + (i % 4));
      bus.cmd_src1 = 2'(i);
      bus.cmd_src2 = 2'(i + 1);
      bus.cmd_imm  = 32'h100 + 32'(i);
      e = 32'h100 + 32'(4 * (i / 4));
      chk("stream_ready", {31'd0, bus.cmd_ready}, {31'd0, (i % 4) == 0});
      if (bus.cmd_ready) acc++;
      if ((i % 4) == 2) begin
        chk("stream_write", {31'd0, bus.rb_write}, 32'd1);
        chk("stream_dr", {30'd0, bus.rb_dr}, 32'(i / 4));
        chk("stream_wrdata", bus.rb_wrData, e);
      end
      if ((i % 4) == 3) begin
        chk("stream_rsp_data", bus.rsp_data, e);
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("stream_accepts", 32'(acc), 32'd3);

    run_cmd(2'd3, 2'd3, 2'd0, 2'd0, 32'h0, 32'h00000100, 1'b0, 0);
    run_cmd(2'd3, 2'd3, 2'd1, 2'd0, 32'h0, 32'h00000104, 1'b0, 0);
    run_cmd(2'd3, 2'd3, 2'd2, 2'd0, 32'h0, 32'h00000108, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
